// File: rtl/addr_load_ctrl.sv
// Frame sequencer for the MCU-filled serial address shift register: gates shifting,
// captures the address and optionally auto-increments it (macro ADDR_LOAD_AUTOINC_EN).
module addr_load_ctrl #(
    parameter int unsigned DWIDTH   = 21,
    parameter int unsigned INC_STEP = 1,
    parameter int unsigned CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_n,
    input  logic              bit_valid,
    input  logic              ser_data,
    input  logic [DWIDTH-1:0] sreg_q,
    output logic              sreg_en_n,
    output logic              sreg_in,
    output logic [DWIDTH-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_inc,
    output logic              busy,
    output logic              err_short,
    output logic              err_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        READY = 2'd3
    } state_t;

    state_t            state_q;
    logic              frame_n_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DWIDTH-1:0] addr_q;
    logic              addr_valid_q;
    logic              busy_q;
    logic              err_short_q;
    logic              err_overrun_q;
    logic              frame_start;

    assign frame_start = frame_n_q & ~frame_n;

    // Shift only while a frame is open and a bit is actually offered
    assign sreg_en_n = ~((state_q == SHIFT) & bit_valid & ~frame_n);
    assign sreg_in   = ser_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            frame_n_q     <= 1'b1;
            cnt_q         <= '0;
            addr_q        <= '0;
            addr_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            frame_n_q <= frame_n;
            if (frame_start && (state_q != SHIFT)) begin
                state_q       <= SHIFT;
                cnt_q         <= '0;
                addr_valid_q  <= 1'b0;
                busy_q        <= 1'b1;
                err_short_q   <= 1'b0;
                err_overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    SHIFT: begin
                        if (frame_n) begin
                            err_short_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end else if (bit_valid) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(DWIDTH - 1)) state_q <= LATCH;
                        end
                    end
                    LATCH: begin
                        addr_q       <= sreg_q;
                        addr_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= READY;
                    end
                    READY: begin
`ifdef ADDR_LOAD_AUTOINC_EN
                        if (addr_inc) addr_q <= addr_q + DWIDTH'(INC_STEP);
`endif
                        // Extra bits after a complete frame are flagged, never shifted
                        if (bit_valid && !frame_n) err_overrun_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifndef ADDR_LOAD_AUTOINC_EN
    logic unused_inc;
    assign unused_inc = addr_inc ^ (|DWIDTH'(INC_STEP));
`endif

    assign addr        = addr_q;
    assign addr_valid  = addr_valid_q;
    assign busy        = busy_q;
    assign err_short   = err_short_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: doc/addr_load_ctrl.md
Name: addr_load_ctrl

Overview:
Sequences the DWIDTH-bit serial address shift register that the MCU fills bit by bit over the CPLD bus. It detects a frame and gates the register's active-low shift enable for exactly DWIDTH accepted bits. It then captures the parallel register contents into a stable address output and optionally auto-increments that address after each memory access. It sits between the MCU-side serial strobe logic and the SRAM address mux.

Parameters:
DWIDTH, 21, address/shift-register width; frame length in bits
INC_STEP, 1, auto-increment step added to addr on each addr_inc pulse
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > DWIDTH

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous reset, active-high
frame_n  input  1  frame select from MCU, active-low; already synchronised to clk
bit_valid  input  1  one-cycle strobe: ser_data holds a new bit
ser_data  input  1  serial bit, MSB first
sreg_q  input  DWIDTH  parallel output of the shift register
sreg_en_n  output  1  shift enable to the register, active-low
sreg_in  output  1  serial bit to the register
addr  output  DWIDTH  captured/current address
addr_valid  output  1  addr holds a complete frame
addr_inc  input  1  one-cycle pulse: advance addr by INC_STEP
busy  output  1  frame in progress (SHIFT or LATCH)
err_short  output  1  sticky: frame ended before DWIDTH bits
err_overrun  output  1  sticky: bit received after frame complete

Behaviour:
- Reset values: sreg_en_n=1, addr=0, addr_valid=0, busy=0, err_short=0, err_overrun=0, state=IDLE, counter=0. Internal frame_n_d resets to 1.
- Frame start = frame_n_d==1 && frame_n==0, the registered falling edge. In any state except SHIFT, a frame start moves to SHIFT, clears counter, addr_valid, err_short and err_overrun, and sets busy. bit_valid in the start cycle is ignored.
- sreg_en_n is combinational: 0 iff state==SHIFT && bit_valid && frame_n==0. sreg_in is combinational: sreg_in=ser_data.
- States:
  - IDLE: sreg_en_n=1; wait for frame start.
  - SHIFT: each accepted bit increments the counter. On the bit where counter==DWIDTH-1, go to LATCH. If frame_n==1 before that bit, set err_short=1, go to IDLE, and leave addr_valid at 0; addr keeps its old value.
  - LATCH: single cycle; addr<=sreg_q, addr_valid<=1, busy<=0; then READY. addr_valid therefore rises one clock after the edge that shifted the last bit.
  - READY: addr_inc makes addr<=(addr+INC_STEP) mod 2^DWIDTH. A bit_valid while frame_n==0 sets err_overrun=1; the register is not shifted and addr is unchanged. frame_n rising leaves the state in READY.
- Simultaneous events:
  - Frame start with addr_inc: the frame wins and the increment is dropped.
  - addr_inc in IDLE, SHIFT or LATCH: ignored.
- Reset mid-frame returns everything to reset values immediately. The shift register is not reset, but any later complete frame overwrites all DWIDTH bits, so stale contents never reach addr.
- A short frame leaves the register partially shifted. It is harmless, since addr is captured only in LATCH.

Optional Feature:
ADDR_LOAD_AUTOINC_EN:
- Defined: addr_inc behaves as above.
- Undefined: addr_inc is ignored, addr changes only in LATCH, and the incrementer is not synthesised. This saves macrocells in small CPLD fits.

Test Plan:
- Reset: assert rst with random inputs -> sreg_en_n=1, addr=0, addr_valid=0, busy=0, err_short=0, err_overrun=0.
- Full frame: frame_n low, then 21 bit_valid strobes of 0x12345 MSB first, with a behavioural register on sreg_q -> sreg_en_n low on exactly 21 cycles; addr=0x12345 and addr_valid=1 one clock after the 21st bit; busy=0.
- Short frame: 10 bits, then frame_n high -> err_short=1, addr_valid=0, addr keeps its prior value, state IDLE. The next full frame of 0x0ABCD loads correctly and clears err_short.
- Auto-increment wrap (macro defined): load 0x1FFFFF, pulse addr_inc -> addr=0x000000. Pulse twice more -> addr=0x000002. With the macro undefined -> addr stays 0x1FFFFF.
- Overrun and collision: after loading 0x00010, send a 22nd bit -> err_overrun=1, sreg_en_n stays 1, addr=0x00010. Then apply a frame start and addr_inc in the same cycle -> addr not incremented, addr_valid=0, err_overrun=0.
- Reset mid-frame: after 5 bits, pulse rst -> reset values. The next full frame of 0x15555 -> addr=0x15555.
